shift_reg_ctrl: RTL and testbench

- Sequencer for the team's 8-bit `shift_reg` datapath.
- Accepts a one-cycle job request (word, direction, shift count), parallel-loads the word, issues the requested number of shift commands, then captures the shifted word.
- Sits between a requesting block and `shift_reg`; drives `shift_reg`'s load/data_in and observes its data_out.

---
 rtl/shift_reg_ctrl.sv | 165 ++++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: job sequencer for the 8-bit shift_reg datapath.
// Accepts a one-cycle request (word, direction, count), parallel-loads the
// word into shift_reg, issues `count` shift commands, then captures the
// shifted word and pulses done.
// Optional build macro SHIFT_CTRL_ABORT_EN adds an `abort` input that
// cancels a job in LOAD or SHIFT without producing done.
module shift_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] word_in,
    input  logic [WIDTH-1:0] sr_data_out,
`ifdef SHIFT_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       sr_load,
    output logic [WIDTH-1:0] sr_data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD  = 2'd0;
    localparam logic [1:0] MODE_LOAD  = 2'd1;
    localparam logic [1:0] MODE_RIGHT = 2'd2;
    localparam logic [1:0] MODE_LEFT  = 2'd3;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] word_q;
    logic             dir_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] remaining;
    logic             abort_hit;
    logic             accept;

`ifdef SHIFT_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // A request is only taken while idle; starts during a job are dropped.
    assign accept = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort only has effect in LOAD and SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort_hit) begin
                    state_nxt = IDLE;
                end else if (count_q == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_hit) begin
                    state_nxt = IDLE;
                end else if (remaining == CNT_W'(1)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        sr_load = MODE_HOLD;
        busy    = 1'b0;
        case (state)
            LOAD: begin
                sr_load = MODE_LOAD;
                busy    = 1'b1;
            end
            SHIFT: begin
                sr_load = dir_q ? MODE_LEFT : MODE_RIGHT;
                busy    = 1'b1;
            end
            CAPTURE: begin
                busy    = 1'b1;
            end
            default: begin
                sr_load = MODE_HOLD;
                busy    = 1'b0;
            end
        endcase
    end

    // Job fields latched on an accepted start; the word register feeds
    // sr_data_in directly so it changes exactly as LOAD begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            dir_q   <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            word_q  <= word_in;
            dir_q   <= dir;
            count_q <= count;
        end
    end

    assign sr_data_in = word_q;

    // Shift down-counter: armed in LOAD, decremented per SHIFT edge; SHIFT
    // is left at remaining==1 so the counter never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
        end else if (state == LOAD) begin
            remaining <= abort_hit ? '0 : count_q;
        end else if (state == SHIFT) begin
            remaining <= abort_hit ? '0 : (remaining - CNT_W'(1));
        end
    end

    // Capture the shifted word and pulse done on the edge leaving CAPTURE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == CAPTURE);
            if (state == CAPTURE) begin
                result <= sr_data_out;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl with a zero-fill shift_reg model.
// Honours SHIFT_CTRL_ABORT_EN when the build defines it.
module tb_shift_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dir;
    logic [3:0] count;
    logic [7:0] word_in;
    logic [7:0] sr_data_out;
    logic [1:0] sr_load;
    logic [7:0] sr_data_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
`ifdef SHIFT_CTRL_ABORT_EN
    logic       abort;
`endif

    int total = 0;
    int bad   = 0;

    always #50 clk = ~clk;

    // Zero-fill shift_reg: 0 hold, 1 load, 2 right, 3 left.
    logic [7:0] sr_q = 8'h00;
    always @(posedge clk) begin
        case (sr_load)
            2'd1:    sr_q <= sr_data_in;
            2'd2:    sr_q <= {1'b0, sr_q[7:1]};
            2'd3:    sr_q <= {sr_q[6:0], 1'b0};
            default: sr_q <= sr_q;
        endcase
    end
    assign sr_data_out = sr_q;

    shift_reg_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dir(dir),
        .count(count),
        .word_in(word_in),
        .sr_data_out(sr_data_out),
`ifdef SHIFT_CTRL_ABORT_EN
        .abort(abort),
`endif
        .sr_load(sr_load),
        .sr_data_in(sr_data_in),
        .busy(busy),
        .done(done),
        .result(result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] b2b_load [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
    logic       b2b_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       b2b_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int dones;
        reset   = 1'b0;
        start   = 1'b0;
        dir     = 1'b0;
        count   = 4'd0;
        word_in = 8'h00;
`ifdef SHIFT_CTRL_ABORT_EN
        abort   = 1'b0;
`endif

        // Reset held for two cycles.
        tick();
        tick();
        chk("rst_sr_load", 32'(sr_load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'h00);
        chk("rst_data_in", 32'(sr_data_in), 32'h00);
        reset = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Right shift: 100 >> 3 = 12, done at E5.
        word_in = 8'd100; dir = 1'b0; count = 4'd3; start = 1'b1;
        tick();                                   // E0
        start = 1'b0; word_in = 8'h00;
        chk("r_load", 32'(sr_load), 32'd1);
        chk("r_busy0", 32'(busy), 32'd1);
        chk("r_data_in", 32'(sr_data_in), 32'd100);
        tick();                                   // E1
        chk("r_sh1", 32'(sr_load), 32'd2);
        tick();                                   // E2
        chk("r_sh2", 32'(sr_load), 32'd2);
        tick();                                   // E3
        chk("r_sh3", 32'(sr_load), 32'd2);
        chk("r_done_early", 32'(done), 32'd0);
        tick();                                   // E4
        chk("r_cap", 32'(sr_load), 32'd0);
        chk("r_busy4", 32'(busy), 32'd1);
        chk("r_done4", 32'(done), 32'd0);
        tick();                                   // E5
        chk("r_done", 32'(done), 32'd1);
        chk("r_busy5", 32'(busy), 32'd0);
        chk("r_result", 32'(result), 32'd12);
        chk("r_data_in_hold", 32'(sr_data_in), 32'd100);
        tick();
        chk("r_done_clr", 32'(done), 32'd0);
        chk("r_result_hold", 32'(result), 32'd12);

        // Left shift: 100 << 2 = 144, done at E4.
        word_in = 8'd100; dir = 1'b1; count = 4'd2; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        chk("l_load", 32'(sr_load), 32'd1);
        tick();
        chk("l_sh1", 32'(sr_load), 32'd3);
        tick();
        chk("l_sh2", 32'(sr_load), 32'd3);
        tick();
        chk("l_cap", 32'(sr_load), 32'd0);
        chk("l_done3", 32'(done), 32'd0);
        tick();                                   // E4
        chk("l_done", 32'(done), 32'd1);
        chk("l_result", 32'(result), 32'd144);
        tick();

        // Zero count: LOAD then CAPTURE, done at E2.
        word_in = 8'hA5; dir = 1'b0; count = 4'd0; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        chk("z_load", 32'(sr_load), 32'd1);
        tick();
        chk("z_cap", 32'(sr_load), 32'd0);
        chk("z_busy", 32'(busy), 32'd1);
        tick();                                   // E2
        chk("z_done", 32'(done), 32'd1);
        chk("z_result", 32'(result), 32'hA5);
        tick();

        // Async reset in the middle of a SHIFT.
        word_in = 8'h3C; dir = 1'b0; count = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("m_pre_sh", 32'(sr_load), 32'd2);
        reset = 1'b0;
        #1;
        chk("m_sr_load", 32'(sr_load), 32'd0);
        chk("m_busy", 32'(busy), 32'd0);
        chk("m_done", 32'(done), 32'd0);
        chk("m_result", 32'(result), 32'h00);
        chk("m_data_in", 32'(sr_data_in), 32'h00);
        tick();
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dones++;
        end
        chk("m_no_done", 32'(dones), 32'd0);
        chk("m_idle", 32'(busy), 32'd0);

        // Back-to-back with start held high; busy-time starts carry junk.
        word_in = 8'hFF; dir = 1'b0; count = 4'd1; start = 1'b1;
        tick();                                   // first job accepted
        dones = 0;
        for (int j = 0; j < 2; j++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) begin
                    word_in = 8'h0F; dir = 1'b1; count = 4'd0;
                end
                if (c == 3) begin
                    word_in = 8'hFF; dir = 1'b0; count = 4'd1;
                    if (j == 1) start = 1'b0;
                end
                chk($sformatf("b%0d_load%0d", j, c), 32'(sr_load), 32'(b2b_load[c]));
                chk($sformatf("b%0d_busy%0d", j, c), 32'(busy), 32'(b2b_busy[c]));
                chk($sformatf("b%0d_done%0d", j, c), 32'(done), 32'(b2b_done[c]));
                if (c == 3) begin
                    chk($sformatf("b%0d_result", j), 32'(result), 32'h7F);
                end
                if (done) dones++;
                tick();
            end
        end
        chk("b_done_count", 32'(dones), 32'd2);
        chk("b_end_busy", 32'(busy), 32'd0);
        chk("b_end_done", 32'(done), 32'd0);

`ifdef SHIFT_CTRL_ABORT_EN
        // Abort in the second SHIFT cycle of a count=5 job.
        word_in = 8'h55; dir = 1'b0; count = 4'd5; start = 1'b1;
        tick();                                   // LOAD
        start = 1'b0;
        tick();                                   // SHIFT 1
        tick();                                   // SHIFT 2
        chk("a_sh2", 32'(sr_load), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_sr_load", 32'(sr_load), 32'd0);
        chk("a_busy", 32'(busy), 32'd0);
        chk("a_done", 32'(done), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dones++;
        end
        chk("a_no_done", 32'(dones), 32'd0);
        chk("a_result", 32'(result), 32'h7F);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
